traffic_light_monitor: RTL and testbench
========================================

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter GREEN_MIN, default 4, minimum legal green phase length in clk cycles.
REQ-002 Parameter GREEN_MAX, default 8, maximum legal green phase length in clk cycles.
REQ-003 Parameter YELLOW_LEN, default 2, exact required yellow phase length in clk cycles.
REQ-004 Parameter CNT_W, default 8, width of the phase-duration counters.
REQ-005 clk  input  1  single clock; all sampling is on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 street_a  input  3  street A lamps, one-hot {red, yellow, green}: bit2 red, bit1 yellow, bit0 green.
REQ-008 street_a_pri_lamp  input  1  street A priority lamp.
REQ-009 street_b  input  3  street B lamps, same encoding as street_a.
REQ-010 street_b_pri_lamp  input  1  street B priority lamp.
REQ-011 clr_fault  input  1  synchronous clear of fault and err_code.
REQ-012 err_valid  output  1  one-cycle pulse for any violation detected.
REQ-013 err_code  output  4  code of the first violation since the last clear.
REQ-014 fault  output  1  sticky flag: at least one violation since the last clear.
REQ-015 last_dur_a / last_dur_b  output  CNT_W  length of the last completed phase per street.
REQ-016 phase_done  output  2  per-street pulse (bit0 A, bit1 B) when a phase ends.

Function
REQ-017 Each street tracker has states UNKNOWN, GREEN, YELLOW and RED, with a saturating duration counter that restarts at 1 on entry to a state.
REQ-018 UNKNOWN is left on the first valid one-hot lamp value, which is adopted without a sequence check.
REQ-019 Legal transitions are GREEN->YELLOW, YELLOW->RED and RED->GREEN; any other change raises a sequence error, and the tracker adopts the new state.
REQ-020 Lamp value not one-hot (000, 011, 111, ...): raise a one-hot error; the tracker holds state and the counter keeps counting.
REQ-021 On leaving GREEN with duration < GREEN_MIN, or on leaving YELLOW with duration != YELLOW_LEN: raise a timing error.
REQ-022 When the GREEN duration reaches GREEN_MAX+1: raise a timing error once in that cycle, not again in the same phase.
REQ-023 Conflict: neither street red bit set in the same sample; raise a conflict error in every such cycle.
REQ-024 Priority error: a pri_lamp set while its own street is not green, or both pri_lamps set together.
REQ-025 err_code values: 1 one-hot A, 2 one-hot B, 3 conflict, 4 sequence A, 5 sequence B, 6 timing A, 7 timing B, 8 priority; 0 means none.
REQ-026 Simultaneous violations: the lowest code wins, and err_valid pulses once.
REQ-027 Latency: a violation sampled at edge N sets err_valid, fault and err_code after edge N+1 (one registered stage).
REQ-028 err_code latches only while fault is 0; later errors pulse err_valid but leave err_code unchanged.
REQ-029 clr_fault clears fault and err_code; if a new violation arrives in the same cycle, the violation wins and is captured.
REQ-030 phase_done pulses and last_dur loads the ending duration with the same one-cycle latency as REQ-027.
REQ-031 Counter saturates at 2^CNT_W-1 and never wraps.

Reset
REQ-032 While rst_n is low: trackers in UNKNOWN, counters 0, err_valid 0, err_code 0, fault 0, last_dur_a/b 0, phase_done 0.
REQ-033 Reset asserted mid-phase aborts tracking immediately; no phase_done or error is generated for the aborted phase.

Structure
REQ-034 Shared package traffic_light_pkg holds the lamp bit positions, the tracker state encoding and the err_code constants.
REQ-035 One sub-module, lamp_tracker, is instantiated once per street; conflict and priority checks plus error arbitration stay in the top module.

Verification (GREEN_MIN=4, GREEN_MAX=8, YELLOW_LEN=2)
REQ-036 Legal cycle on A (G×5, Y×2, R×9) with B mirrored red/green -> no err_valid; last_dur_a = 5, 2, 9 in turn.
REQ-037 A goes GREEN->RED directly -> err_valid one cycle later, err_code=4, fault=1.
REQ-038 Both streets green for 1 cycle, plus A yellow of 3 cycles -> err_code=3 (first error), err_valid pulses again later with err_code still 3.
REQ-039 A green held 12 cycles -> single timing pulse at duration 9, err_code=6; street_a=3'b011 later -> err_valid pulse, err_code unchanged.
REQ-040 street_b_pri_lamp=1 while B red -> err_code=8; clr_fault pulsed with no violation -> fault=0, err_code=0.
REQ-041 rst_n low for 1 cycle mid-green -> all outputs 0 asynchronously; after release, the first lamp value is adopted with no sequence error.

Source files
------------

// File: rtl/traffic_light_pkg.sv
// Shared definitions for the traffic light monitor: lamp bit positions,
// tracker state encoding and violation codes.
package traffic_light_pkg;

  localparam int LAMP_GRN = 0;
  localparam int LAMP_YEL = 1;
  localparam int LAMP_RED = 2;

  localparam logic [2:0] LAMP_G_ONLY = 3'(1 << LAMP_GRN);
  localparam logic [2:0] LAMP_Y_ONLY = 3'(1 << LAMP_YEL);
  localparam logic [2:0] LAMP_R_ONLY = 3'(1 << LAMP_RED);

  localparam logic [1:0] ST_UNKNOWN = 2'd0;
  localparam logic [1:0] ST_GREEN   = 2'd1;
  localparam logic [1:0] ST_YELLOW  = 2'd2;
  localparam logic [1:0] ST_RED     = 2'd3;

  localparam logic [3:0] ERR_NONE     = 4'd0;
  localparam logic [3:0] ERR_ONEHOT_A = 4'd1;
  localparam logic [3:0] ERR_ONEHOT_B = 4'd2;
  localparam logic [3:0] ERR_CONFLICT = 4'd3;
  localparam logic [3:0] ERR_SEQ_A    = 4'd4;
  localparam logic [3:0] ERR_SEQ_B    = 4'd5;
  localparam logic [3:0] ERR_TIMING_A = 4'd6;
  localparam logic [3:0] ERR_TIMING_B = 4'd7;
  localparam logic [3:0] ERR_PRIORITY = 4'd8;

  // Map a lamp sample to a tracker state; anything not one-hot maps to UNKNOWN.
  function automatic logic [1:0] lamp_to_state(input logic [2:0] lamp);
    logic [1:0] st;
    case (lamp)
      LAMP_G_ONLY: st = ST_GREEN;
      LAMP_Y_ONLY: st = ST_YELLOW;
      LAMP_R_ONLY: st = ST_RED;
      default:     st = ST_UNKNOWN;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/lamp_tracker.sv
// Per-street lamp tracker. Follows the phase sequence of one street and
// flags one-hot, sequence and timing violations for the current sample.
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_UNKNOWN | no valid lamp seen since reset; next one-hot is adopted
// ST_GREEN   | green phase, cnt_q = green samples so far
// ST_YELLOW  | yellow phase, cnt_q = yellow samples so far
// ST_RED     | red phase, cnt_q = red samples so far
module lamp_tracker
  import traffic_light_pkg::*;
#(
  parameter int GREEN_MIN  = 4,
  parameter int GREEN_MAX  = 8,
  parameter int YELLOW_LEN = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             smp_vld,
  input  logic [2:0]       lamp,
  output logic             onehot_err,
  output logic             seq_err,
  output logic             tim_err,
  output logic             phase_end,
  output logic [CNT_W-1:0] end_dur
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] G_MIN   = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] G_MAX   = CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] Y_LEN   = CNT_W'(YELLOW_LEN);

  logic [1:0]       st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       lamp_st;
  logic [CNT_W-1:0] cnt_inc;
  logic             green_over;
  logic             legal;

  // Next state, duration count and violation flags for the current sample.
  always_comb begin
    lamp_st    = lamp_to_state(lamp);
    cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    // Fires on the sample that would make the green phase GREEN_MAX+1 long;
    // the equality is only true once per phase because the counter moves on.
    green_over = (st_q == ST_GREEN) && (cnt_q == G_MAX) && (cnt_q != CNT_MAX);
    legal      = ((st_q == ST_GREEN)  && (lamp_st == ST_YELLOW)) ||
                 ((st_q == ST_YELLOW) && (lamp_st == ST_RED))    ||
                 ((st_q == ST_RED)    && (lamp_st == ST_GREEN));
    st_d       = st_q;
    cnt_d      = cnt_q;
    onehot_err = 1'b0;
    seq_err    = 1'b0;
    tim_err    = 1'b0;
    phase_end  = 1'b0;
    end_dur    = cnt_q;
    if (smp_vld) begin
      if (lamp_st == ST_UNKNOWN) begin
        onehot_err = 1'b1;
        if (st_q != ST_UNKNOWN) begin
          cnt_d   = cnt_inc;
          tim_err = green_over;
        end
      end else if (st_q == ST_UNKNOWN) begin
        st_d  = lamp_st;
        cnt_d = CNT_ONE;
      end else if (lamp_st == st_q) begin
        cnt_d   = cnt_inc;
        tim_err = green_over;
      end else begin
        phase_end = 1'b1;
        seq_err   = !legal;
        tim_err   = ((st_q == ST_GREEN)  && (cnt_q < G_MIN)) ||
                    ((st_q == ST_YELLOW) && (cnt_q != Y_LEN));
        st_d      = lamp_st;
        cnt_d     = CNT_ONE;
      end
    end
  end

  // Tracker state and duration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= ST_UNKNOWN;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Traffic light monitor top: samples both streets, runs one lamp tracker
// per street, adds conflict and priority checks, and arbitrates the
// violations into err_valid / err_code / fault.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int GREEN_MIN  = 4,
  parameter int GREEN_MAX  = 8,
  parameter int YELLOW_LEN = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       street_a,
  input  logic             street_a_pri_lamp,
  input  logic [2:0]       street_b,
  input  logic             street_b_pri_lamp,
  input  logic             clr_fault,
  output logic             err_valid,
  output logic [3:0]       err_code,
  output logic             fault,
  output logic [CNT_W-1:0] last_dur_a,
  output logic [CNT_W-1:0] last_dur_b,
  output logic [1:0]       phase_done
);

  logic [2:0]       lamp_a_q, lamp_b_q;
  logic             pri_a_q, pri_b_q, clr_q, smp_vld_q;
  logic             oh_a, seq_a, tim_a, end_a;
  logic             oh_b, seq_b, tim_b, end_b;
  logic [CNT_W-1:0] dur_a, dur_b;
  logic             conflict, pri_err, any_viol;
  logic [3:0]       win_code;

  logic             err_valid_q, err_valid_d;
  logic [3:0]       err_code_q, err_code_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] last_dur_a_q, last_dur_a_d;
  logic [CNT_W-1:0] last_dur_b_q, last_dur_b_d;
  logic [1:0]       phase_done_q, phase_done_d;

  // Input sample stage; smp_vld_q keeps the reset values of the sample
  // registers from being judged as real lamp values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lamp_a_q  <= '0;
      lamp_b_q  <= '0;
      pri_a_q   <= 1'b0;
      pri_b_q   <= 1'b0;
      clr_q     <= 1'b0;
      smp_vld_q <= 1'b0;
    end else begin
      lamp_a_q  <= street_a;
      lamp_b_q  <= street_b;
      pri_a_q   <= street_a_pri_lamp;
      pri_b_q   <= street_b_pri_lamp;
      clr_q     <= clr_fault;
      smp_vld_q <= 1'b1;
    end
  end

  lamp_tracker #(
    .GREEN_MIN (GREEN_MIN),
    .GREEN_MAX (GREEN_MAX),
    .YELLOW_LEN(YELLOW_LEN),
    .CNT_W     (CNT_W)
  ) u_trk_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .smp_vld   (smp_vld_q),
    .lamp      (lamp_a_q),
    .onehot_err(oh_a),
    .seq_err   (seq_a),
    .tim_err   (tim_a),
    .phase_end (end_a),
    .end_dur   (dur_a)
  );

  lamp_tracker #(
    .GREEN_MIN (GREEN_MIN),
    .GREEN_MAX (GREEN_MAX),
    .YELLOW_LEN(YELLOW_LEN),
    .CNT_W     (CNT_W)
  ) u_trk_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .smp_vld   (smp_vld_q),
    .lamp      (lamp_b_q),
    .onehot_err(oh_b),
    .seq_err   (seq_b),
    .tim_err   (tim_b),
    .phase_end (end_b),
    .end_dur   (dur_b)
  );

  // Cross-street checks and lowest-code-wins arbitration.
  always_comb begin
    conflict = smp_vld_q && !lamp_a_q[LAMP_RED] && !lamp_b_q[LAMP_RED];
    pri_err  = smp_vld_q &&
               ((pri_a_q && (lamp_a_q != LAMP_G_ONLY)) ||
                (pri_b_q && (lamp_b_q != LAMP_G_ONLY)) ||
                (pri_a_q && pri_b_q));
    any_viol = oh_a || oh_b || conflict || seq_a || seq_b ||
               tim_a || tim_b || pri_err;
    if (oh_a)          win_code = ERR_ONEHOT_A;
    else if (oh_b)     win_code = ERR_ONEHOT_B;
    else if (conflict) win_code = ERR_CONFLICT;
    else if (seq_a)    win_code = ERR_SEQ_A;
    else if (seq_b)    win_code = ERR_SEQ_B;
    else if (tim_a)    win_code = ERR_TIMING_A;
    else if (tim_b)    win_code = ERR_TIMING_B;
    else if (pri_err)  win_code = ERR_PRIORITY;
    else               win_code = ERR_NONE;
  end

  // Output register inputs: a violation beats a clear in the same cycle.
  always_comb begin
    err_valid_d  = any_viol;
    fault_d      = fault_q;
    err_code_d   = err_code_q;
    if (any_viol) begin
      fault_d = 1'b1;
      if (!fault_q || clr_q) err_code_d = win_code;
    end else if (clr_q) begin
      fault_d    = 1'b0;
      err_code_d = ERR_NONE;
    end
    phase_done_d = {end_b, end_a};
    last_dur_a_d = end_a ? dur_a : last_dur_a_q;
    last_dur_b_d = end_b ? dur_b : last_dur_b_q;
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
      fault_q      <= 1'b0;
      last_dur_a_q <= '0;
      last_dur_b_q <= '0;
      phase_done_q <= '0;
    end else begin
      err_valid_q  <= err_valid_d;
      err_code_q   <= err_code_d;
      fault_q      <= fault_d;
      last_dur_a_q <= last_dur_a_d;
      last_dur_b_q <= last_dur_b_d;
      phase_done_q <= phase_done_d;
    end
  end

  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;
  assign fault      = fault_q;
  assign last_dur_a = last_dur_a_q;
  assign last_dur_b = last_dur_b_q;
  assign phase_done = phase_done_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: directed scenarios plus a
// randomized run, all compared against a phase/duration reference model.
module tb_traffic_light_monitor;

  localparam int GREEN_MIN  = 4;
  localparam int GREEN_MAX  = 8;
  localparam int YELLOW_LEN = 2;
  localparam int CNT_W      = 8;
  localparam int SAT        = (1 << CNT_W) - 1;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [2:0]       street_a = R;
  logic [2:0]       street_b = R;
  logic             street_a_pri_lamp = 1'b0;
  logic             street_b_pri_lamp = 1'b0;
  logic             clr_fault = 1'b0;
  logic             err_valid;
  logic [3:0]       err_code;
  logic             fault;
  logic [CNT_W-1:0] last_dur_a, last_dur_b;
  logic [1:0]       phase_done;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: phase 0 none, 1 green, 2 yellow, 3 red; run = samples in phase.
  int m_ph[2];
  int m_run[2];
  bit m_fault;
  int m_code;
  bit nxt_ev, nxt_fault;
  int nxt_code;
  bit [1:0] nxt_pd;
  int nxt_ld[2];
  logic             exp_ev, exp_fault;
  logic [3:0]       exp_code;
  logic [1:0]       exp_pd;
  logic [CNT_W-1:0] exp_ld_a, exp_ld_b;

  traffic_light_monitor #(
    .GREEN_MIN (GREEN_MIN),
    .GREEN_MAX (GREEN_MAX),
    .YELLOW_LEN(YELLOW_LEN),
    .CNT_W     (CNT_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .street_a         (street_a),
    .street_a_pri_lamp(street_a_pri_lamp),
    .street_b         (street_b),
    .street_b_pri_lamp(street_b_pri_lamp),
    .clr_fault        (clr_fault),
    .err_valid        (err_valid),
    .err_code         (err_code),
    .fault            (fault),
    .last_dur_a       (last_dur_a),
    .last_dur_b       (last_dur_b),
    .phase_done       (phase_done)
  );

  always #5 clk = ~clk;

  function automatic int phase_of(input logic [2:0] l);
    if (l == G) return 1;
    if (l == Y) return 2;
    if (l == R) return 3;
    return 0;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 2; s++) begin
      m_ph[s] = 0; m_run[s] = 0; nxt_ld[s] = 0;
    end
    m_fault = 0; m_code = 0;
    nxt_ev = 0; nxt_fault = 0; nxt_code = 0; nxt_pd = '0;
    exp_ev = 0; exp_fault = 0; exp_code = '0; exp_pd = '0;
    exp_ld_a = '0; exp_ld_b = '0;
  endfunction

  // Applies the rules to one sample and predicts the outputs one cycle later.
  task automatic model_sample(input logic [2:0] a, input logic ap,
                              input logic [2:0] b, input logic bp, input logic clr);
    logic [2:0] lamp[2];
    bit hit[9];
    int first;
    lamp[0] = a; lamp[1] = b;
    for (int k = 0; k < 9; k++) hit[k] = 0;
    nxt_pd = '0;
    for (int s = 0; s < 2; s++) begin
      int p;
      p = phase_of(lamp[s]);
      if (p == 0 || (m_ph[s] != 0 && p == m_ph[s])) begin
        if (p == 0) hit[1+s] = 1;
        if (m_ph[s] != 0) begin
          if (m_ph[s] == 1 && m_run[s] + 1 == GREEN_MAX + 1) hit[6+s] = 1;
          m_run[s] = (m_run[s] < SAT) ? m_run[s] + 1 : SAT;
        end
      end else if (m_ph[s] == 0) begin
        m_ph[s] = p; m_run[s] = 1;
      end else begin
        if (p != (m_ph[s] % 3) + 1) hit[4+s] = 1;
        if ((m_ph[s] == 1 && m_run[s] < GREEN_MIN) ||
            (m_ph[s] == 2 && m_run[s] != YELLOW_LEN)) hit[6+s] = 1;
        nxt_pd[s] = 1'b1;
        nxt_ld[s] = m_run[s];
        m_ph[s] = p; m_run[s] = 1;
      end
    end
    if (!a[2] && !b[2]) hit[3] = 1;
    if ((ap && a != G) || (bp && b != G) || (ap && bp)) hit[8] = 1;
    first = 0;
    for (int k = 8; k >= 1; k--) if (hit[k]) first = k;
    nxt_ev = (first != 0);
    if (first != 0) begin
      if (!m_fault || clr) m_code = first;
      m_fault = 1;
    end else if (clr) begin
      m_fault = 0; m_code = 0;
    end
    nxt_fault = m_fault;
    nxt_code = m_code;
  endtask

  // Drive one sample, clock it, and observe the outputs for the previous sample.
  task automatic step(input logic [2:0] a, input logic ap,
                      input logic [2:0] b, input logic bp, input logic clr);
    street_a = a; street_a_pri_lamp = ap;
    street_b = b; street_b_pri_lamp = bp;
    clr_fault = clr;
    @(posedge clk);
    exp_ev = nxt_ev; exp_fault = nxt_fault; exp_code = 4'(nxt_code);
    exp_pd = nxt_pd; exp_ld_a = CNT_W'(nxt_ld[0]); exp_ld_b = CNT_W'(nxt_ld[1]);
    model_sample(a, ap, b, bp, clr);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    street_a = R; street_b = R;
    street_a_pri_lamp = 1'b0; street_b_pri_lamp = 1'b0; clr_fault = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    #3;
    n_vec++; if (err_valid !== 1'b0) begin n_bad++; $display("FAIL reset_err_valid: got %b want 0", err_valid); end
    n_vec++; if (err_code !== 4'd0) begin n_bad++; $display("FAIL reset_err_code: got %0d want 0", err_code); end
    n_vec++; if (fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault: got %b want 0", fault); end
    n_vec++; if (last_dur_a !== '0) begin n_bad++; $display("FAIL reset_last_dur_a: got %0d want 0", last_dur_a); end
    n_vec++; if (last_dur_b !== '0) begin n_bad++; $display("FAIL reset_last_dur_b: got %0d want 0", last_dur_b); end
    n_vec++; if (phase_done !== 2'b00) begin n_bad++; $display("FAIL reset_phase_done: got %b want 00", phase_done); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(G, 0, R, 0, 0);
    step(G, 0, R, 0, 0);
    n_vec++; if (err_valid !== 1'b0 || fault !== 1'b0) begin
      n_bad++; $display("FAIL first_adopt: got err_valid=%b fault=%b want 0 0", err_valid, fault);
    end
  endtask

  task automatic test_legal_cycle();
    int durs[$];
    logic [2:0] a, b;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      if (i < 5) a = G; else if (i < 7) a = Y; else if (i < 16) a = R; else a = G;
      if (i < 7) b = R; else if (i < 14) b = G; else if (i < 16) b = Y; else b = R;
      step(a, 0, b, 0, 0);
      n_vec++; if (err_valid !== 1'b0) begin n_bad++; $display("FAIL legal_no_err step %0d: got %b want 0", i, err_valid); end
      n_vec++; if (last_dur_a !== exp_ld_a || phase_done !== exp_pd) begin
        n_bad++; $display("FAIL legal_dur step %0d: got dur=%0d pd=%b want dur=%0d pd=%b", i, last_dur_a, phase_done, exp_ld_a, exp_pd);
      end
      if (phase_done[0]) durs.push_back(int'(last_dur_a));
    end
    n_vec++; if (durs.size() != 3) begin n_bad++; $display("FAIL legal_count: got %0d phases want 3", durs.size()); end
    else begin
      n_vec++; if (durs[0] != 5 || durs[1] != 2 || durs[2] != 9) begin
        n_bad++; $display("FAIL legal_durs: got %0d,%0d,%0d want 5,2,9", durs[0], durs[1], durs[2]);
      end
    end
  endtask

  task automatic test_seq_error();
    do_reset();
    for (int i = 0; i < 5; i++) step(G, 0, R, 0, 0);
    step(R, 0, R, 0, 0);
    n_vec++; if (err_valid !== 1'b0) begin n_bad++; $display("FAIL seq_latency: got %b want 0", err_valid); end
    step(R, 0, R, 0, 0);
    n_vec++; if (err_valid !== 1'b1 || err_code !== 4'd4 || fault !== 1'b1) begin
      n_bad++; $display("FAIL seq_err: got ev=%b code=%0d fault=%b want 1 4 1", err_valid, err_code, fault);
    end
    step(R, 0, R, 0, 0);
    n_vec++; if (err_valid !== 1'b0 || fault !== 1'b1) begin
      n_bad++; $display("FAIL seq_pulse: got ev=%b fault=%b want 0 1", err_valid, fault);
    end
  endtask

  task automatic test_conflict();
    logic [2:0] a, b;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      a = (i < 5) ? G : ((i < 8) ? Y : R);
      b = (i == 3) ? G : R;
      step(a, 0, b, 0, 0);
      n_vec++; if (err_valid !== exp_ev || err_code !== exp_code) begin
        n_bad++; $display("FAIL conflict_model step %0d: got ev=%b code=%0d want %b %0d", i, err_valid, err_code, exp_ev, exp_code);
      end
      if (i == 4) begin
        n_vec++; if (err_valid !== 1'b1 || err_code !== 4'd3) begin
          n_bad++; $display("FAIL conflict_first: got ev=%b code=%0d want 1 3", err_valid, err_code);
        end
      end
      if (i == 9) begin
        n_vec++; if (err_valid !== 1'b1 || err_code !== 4'd3 || fault !== 1'b1) begin
          n_bad++; $display("FAIL conflict_later: got ev=%b code=%0d fault=%b want 1 3 1", err_valid, err_code, fault);
        end
      end
    end
  endtask

  task automatic test_green_max();
    int pulses;
    pulses = 0;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      step((i == 12) ? 3'b011 : G, 0, R, 0, 0);
      if (i < 13 && err_valid === 1'b1) pulses++;
      if (i == 9) begin
        n_vec++; if (err_valid !== 1'b1 || err_code !== 4'd6) begin
          n_bad++; $display("FAIL green_max: got ev=%b code=%0d want 1 6", err_valid, err_code);
        end
      end
      if (i == 13) begin
        n_vec++; if (err_valid !== 1'b1 || err_code !== 4'd6) begin
          n_bad++; $display("FAIL onehot_keep_code: got ev=%b code=%0d want 1 6", err_valid, err_code);
        end
      end
    end
    n_vec++; if (pulses != 1) begin n_bad++; $display("FAIL green_max_once: got %0d pulses want 1", pulses); end
  endtask

  task automatic test_priority_clear();
    do_reset();
    step(G, 0, R, 0, 0);
    step(G, 0, R, 1, 0);
    step(G, 0, R, 0, 0);
    n_vec++; if (err_valid !== 1'b1 || err_code !== 4'd8 || fault !== 1'b1) begin
      n_bad++; $display("FAIL priority: got ev=%b code=%0d fault=%b want 1 8 1", err_valid, err_code, fault);
    end
    step(G, 0, R, 0, 1);
    step(G, 0, R, 0, 0);
    n_vec++; if (err_valid !== 1'b0 || err_code !== 4'd0 || fault !== 1'b0) begin
      n_bad++; $display("FAIL clear: got ev=%b code=%0d fault=%b want 0 0 0", err_valid, err_code, fault);
    end
    step(G, 0, R, 0, 1);
    step(G, 1, R, 1, 1);
    step(G, 0, R, 0, 0);
    n_vec++; if (err_valid !== 1'b1 || err_code !== 4'd8 || fault !== 1'b1) begin
      n_bad++; $display("FAIL clear_vs_viol: got ev=%b code=%0d fault=%b want 1 8 1", err_valid, err_code, fault);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] a;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      a = (i < 5) ? G : ((i < 7) ? Y : ((i < 10) ? R : G));
      step(a, 0, R, (i == 0), 0);
    end
    n_vec++; if (fault !== 1'b1 || last_dur_a !== 8'd3) begin
      n_bad++; $display("FAIL pre_reset: got fault=%b dur_a=%0d want 1 3", fault, last_dur_a);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (err_valid !== 1'b0 || err_code !== 4'd0 || fault !== 1'b0 ||
                 last_dur_a !== '0 || last_dur_b !== '0 || phase_done !== 2'b00) begin
      n_bad++; $display("FAIL async_reset: got ev=%b code=%0d fault=%b da=%0d db=%0d pd=%b want all 0",
                        err_valid, err_code, fault, last_dur_a, last_dur_b, phase_done);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step(R, 0, G, 0, 0);
      n_vec++; if (err_valid !== 1'b0 || fault !== 1'b0 || phase_done !== 2'b00) begin
        n_bad++; $display("FAIL post_reset_adopt %0d: got ev=%b fault=%b pd=%b want 0 0 00", i, err_valid, fault, phase_done);
      end
    end
  endtask

  task automatic test_random();
    int gph[2], left[2];
    logic [2:0] l[2];
    do_reset();
    for (int s = 0; s < 2; s++) begin
      gph[s] = (s == 0) ? 1 : 3; left[s] = $urandom_range(1, 8);
    end
    for (int i = 0; i < 600; i++) begin
      for (int s = 0; s < 2; s++) begin
        if (left[s] == 0) begin
          gph[s] = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 3) : (gph[s] % 3) + 1;
          left[s] = (gph[s] == 1) ? $urandom_range(2, 10) :
                    ((gph[s] == 2) ? $urandom_range(1, 3) : $urandom_range(1, 12));
        end
        left[s]--;
        l[s] = (gph[s] == 1) ? G : ((gph[s] == 2) ? Y : R);
        if ($urandom_range(0, 15) == 0) l[s] = 3'($urandom_range(0, 7));
      end
      step(l[0], ($urandom_range(0, 19) == 0), l[1], ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 15) == 0));
      n_vec++; if (err_valid !== exp_ev) begin n_bad++; $display("FAIL rnd_err_valid %0d: got %b want %b", i, err_valid, exp_ev); end
      n_vec++; if (err_code !== exp_code) begin n_bad++; $display("FAIL rnd_err_code %0d: got %0d want %0d", i, err_code, exp_code); end
      n_vec++; if (fault !== exp_fault) begin n_bad++; $display("FAIL rnd_fault %0d: got %b want %b", i, fault, exp_fault); end
      n_vec++; if (phase_done !== exp_pd) begin n_bad++; $display("FAIL rnd_phase_done %0d: got %b want %b", i, phase_done, exp_pd); end
      n_vec++; if (last_dur_a !== exp_ld_a) begin n_bad++; $display("FAIL rnd_last_dur_a %0d: got %0d want %0d", i, last_dur_a, exp_ld_a); end
      n_vec++; if (last_dur_b !== exp_ld_b) begin n_bad++; $display("FAIL rnd_last_dur_b %0d: got %0d want %0d", i, last_dur_b, exp_ld_b); end
    end
  endtask

  initial begin
    test_reset();
    test_legal_cycle();
    test_seq_error();
    test_conflict();
    test_green_max();
    test_priority_clear();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
